ptmch_trg_seq: RTL and testbench
================================

# ptmch_trg_seq

Trigger pulse-train sequencer for the ptmch trigger path. It takes a configuration word set decoded from the SPI command stream and a one-cycle START strobe. It then drives TRG_PLS as a programmable train: an initial delay, then COUNT pulses of WIDTH cycles each, with rising edges PERIOD cycles apart. It sits between the SPI register decoder and the TRG_PLS pin, in the CLK160M domain.

## Interface
- CNT_W, 16, width of the delay, width and period counters (cycles)
- NUM_W, 8, width of the pulse-count field
- CLK160M  in  1  system clock, 160 MHz; all logic on the rising edge
- RESET  in  1  synchronous reset, active-high
- START  in  1  one-cycle strobe that requests a pulse train
- ABORT  in  1  one-cycle strobe that terminates the train immediately
- CFG_DELAY  in  CNT_W  cycles from START capture to the first rising edge, minus 1
- CFG_WIDTH  in  CNT_W  high time per pulse, in cycles; must be ≥1
- CFG_PERIOD  in  CNT_W  rising-edge to rising-edge spacing, in cycles; must be > CFG_WIDTH
- CFG_COUNT  in  NUM_W  number of pulses; must be ≥1
- TRG_PLS  out  1  trigger output, registered
- BUSY  out  1  high while a train is in progress
- DONE  out  1  one-cycle pulse when the train completes normally
- CFG_ERR  out  1  one-cycle pulse when START carries an illegal configuration

## Operation
- States: IDLE, DELAY, HIGH, LOW.
- IDLE + START: all four CFG_* inputs are latched into shadow registers. CFG_* changes after this point have no effect until the next START.
- Illegal config (WIDTH=0, COUNT=0, or PERIOD≤WIDTH):
  - CFG_ERR=1 for one cycle.
  - Stay in IDLE; BUSY stays 0.
- Legal config: go to DELAY with the delay counter loaded with CFG_DELAY.
  - DELAY counts down; at 0 → HIGH.
- HIGH: TRG_PLS=1 for WIDTH cycles, then LOW. The pulse counter decrements on each HIGH→LOW transition.
- LOW: TRG_PLS=0 for PERIOD−WIDTH cycles, then HIGH.
- Last pulse: when its HIGH phase ends, go directly to IDLE (the trailing LOW phase is skipped). DONE=1 and BUSY=0 in that same cycle.
- START while BUSY is ignored: no error, and the train continues unchanged.
- ABORT in any non-IDLE state:
  - Next cycle: TRG_PLS=0, BUSY=0, state IDLE; DONE is not asserted.
  - ABORT in IDLE has no effect.
- START and ABORT in the same cycle while IDLE: ABORT wins and START is dropped.
- Counters are CNT_W / NUM_W unsigned and never wrap. A full-scale value, e.g. PERIOD=2^CNT_W−1, is legal.

## Timing
- Reset values: TRG_PLS=0, BUSY=0, DONE=0, CFG_ERR=0, state IDLE, all counters 0.
- RESET asserted mid-train: all outputs are 0 in the following cycle, with no DONE.
- START sampled at edge n:
  - BUSY=1 from edge n+1.
  - Pulse k (k=0…COUNT−1): TRG_PLS rises at edge n+1+DELAY+k·PERIOD and falls WIDTH cycles later.
  - DONE and the BUSY fall occur at edge n+1+DELAY+(COUNT−1)·PERIOD+WIDTH.
- CFG_ERR is asserted at edge n+1.
- A new START is accepted in the cycle in which DONE is high. Back-to-back trains therefore have zero idle cycles between DONE and the next capture.
- Pulse width and period are exact to the cycle; there is no jitter across pulses.

## Structure
- The shared package ptmch_pkg holds:
  - the state enum typedef ptmch_trg_seq_st_t (IDLE, DELAY, HIGH, LOW);
  - default localparams PTMCH_CNT_W=16 and PTMCH_NUM_W=8.
- One sub-module, ptmch_dncnt: a loadable down-counter (load, enable, zero flag, parameterised width).
  - Instantiated three times: delay/phase, period, pulse count.
- The FSM and the shadow registers live in ptmch_trg_seq itself.
- The instantiation point is between the SPI decoder and TRG_PLS inside the trigger block.

## Test plan
- DELAY=2, WIDTH=3, PERIOD=5, COUNT=3, START at edge 0 → TRG_PLS high over edges 3–5, 8–10, 13–15; DONE at edge 16; BUSY high over edges 1–15.
- DELAY=0, WIDTH=1, PERIOD=2, COUNT=1 → TRG_PLS high only at edge 1; DONE at edge 2.
- Illegal configs (WIDTH=0; COUNT=0; PERIOD=WIDTH=4) → CFG_ERR pulse at edge 1; TRG_PLS and BUSY stay 0.
- Mid-train disruptions on the first scenario:
  - ABORT at edge 9 → TRG_PLS=0 and BUSY=0 at edge 10; no DONE; later pulses absent.
  - RESET at edge 9 → the same observable result.
- Second START at edge 4 with different CFG, plus CFG changes mid-train → output identical to the first scenario.
- Second START in the DONE cycle → new train runs with its own timing.
- START and ABORT in the same cycle while IDLE → no train.

Source files
------------

// File: rtl/ptmch_pkg.sv
// Shared types and default widths for the ptmch trigger path.
package ptmch_pkg;

  localparam int PTMCH_CNT_W = 16;
  localparam int PTMCH_NUM_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW
  } ptmch_trg_seq_st_t;

endpackage

// File: rtl/ptmch_trg_seq_if.sv
// Command/status bundle between the SPI register decoder and the trigger sequencer.
interface ptmch_trg_seq_if #(
  parameter int CNT_W = ptmch_pkg::PTMCH_CNT_W,
  parameter int NUM_W = ptmch_pkg::PTMCH_NUM_W
);

  logic             START;
  logic             ABORT;
  logic [CNT_W-1:0] CFG_DELAY;
  logic [CNT_W-1:0] CFG_WIDTH;
  logic [CNT_W-1:0] CFG_PERIOD;
  logic [NUM_W-1:0] CFG_COUNT;
  logic             TRG_PLS;
  logic             BUSY;
  logic             DONE;
  logic             CFG_ERR;

  modport master (
    output START, ABORT, CFG_DELAY, CFG_WIDTH, CFG_PERIOD, CFG_COUNT,
    input  TRG_PLS, BUSY, DONE, CFG_ERR
  );

  modport slave (
    input  START, ABORT, CFG_DELAY, CFG_WIDTH, CFG_PERIOD, CFG_COUNT,
    output TRG_PLS, BUSY, DONE, CFG_ERR
  );

endinterface

// File: rtl/ptmch_dncnt.sv
// Loadable saturating down-counter with a zero flag; load has priority over enable.
module ptmch_dncnt #(
  parameter int WIDTH = ptmch_pkg::PTMCH_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;

  // Holds at zero instead of wrapping so a late enable can never restart a phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ptmch_trg_seq.sv
// Trigger pulse-train sequencer: START-captured delay, then COUNT pulses of WIDTH
// cycles spaced PERIOD cycles apart on TRG_PLS.
module ptmch_trg_seq
  import ptmch_pkg::*;
#(
  parameter int CNT_W = PTMCH_CNT_W,
  parameter int NUM_W = PTMCH_NUM_W
) (
  input  logic           CLK160M,
  input  logic           RESET,
  ptmch_trg_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

  ptmch_trg_seq_st_t state;

  logic [CNT_W-1:0] sh_width;
  logic [CNT_W-1:0] sh_period;

  logic trg_q;
  logic busy_q;
  logic done_q;
  logic err_q;

  logic             start_ok;
  logic             cfg_legal;
  logic             go;
  logic             go_high;
  logic             enter_high;
  logic [CNT_W-1:0] high_w;
  logic [CNT_W-1:0] high_p;

  logic             ph_load;
  logic             ph_en;
  logic [CNT_W-1:0] ph_val;
  logic             ph_zero;
  logic             per_load;
  logic             per_en;
  logic [CNT_W-1:0] per_val;
  logic             per_zero;
  logic             num_load;
  logic             num_en;
  logic [NUM_W-1:0] num_val;
  logic             num_zero;

  // Counters are loaded with N-1 so that "zero" marks the last cycle of a phase.
  // A zero delay skips DELAY entirely so the first rising edge lands right after capture.
  always_comb begin
    start_ok   = (state == IDLE) && bus.START && !bus.ABORT;
    cfg_legal  = (bus.CFG_WIDTH != '0) && (bus.CFG_COUNT != '0) &&
                 (bus.CFG_PERIOD > bus.CFG_WIDTH);
    go         = start_ok && cfg_legal;
    go_high    = go && (bus.CFG_DELAY == '0);
    high_w     = go ? bus.CFG_WIDTH  : sh_width;
    high_p     = go ? bus.CFG_PERIOD : sh_period;
    enter_high = go_high ||
                 ((state == DELAY) && ph_zero) ||
                 ((state == LOW) && per_zero);

    ph_load  = go || enter_high;
    ph_val   = enter_high ? (high_w - CNT_ONE) : (bus.CFG_DELAY - CNT_ONE);
    ph_en    = ((state == DELAY) || (state == HIGH)) && !ph_zero;

    per_load = enter_high;
    per_val  = high_p - CNT_ONE;
    per_en   = ((state == HIGH) || (state == LOW)) && !per_zero;

    num_load = go;
    num_val  = bus.CFG_COUNT - NUM_ONE;
    num_en   = (state == HIGH) && ph_zero;
  end

  ptmch_dncnt #(.WIDTH(CNT_W)) u_phase_cnt (
    .clk      (CLK160M),
    .rst      (RESET),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ph_en),
    .zero     (ph_zero)
  );

  ptmch_dncnt #(.WIDTH(CNT_W)) u_period_cnt (
    .clk      (CLK160M),
    .rst      (RESET),
    .load     (per_load),
    .load_val (per_val),
    .en       (per_en),
    .zero     (per_zero)
  );

  ptmch_dncnt #(.WIDTH(NUM_W)) u_pulse_cnt (
    .clk      (CLK160M),
    .rst      (RESET),
    .load     (num_load),
    .load_val (num_val),
    .en       (num_en),
    .zero     (num_zero)
  );

  // Delay and count live only in their counters after capture; width and period
  // need shadows because they are reloaded at every rising edge.
  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      state     <= IDLE;
      sh_width  <= '0;
      sh_period <= '0;
      trg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.ABORT && (state != IDLE)) begin
        state  <= IDLE;
        trg_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              sh_width  <= bus.CFG_WIDTH;
              sh_period <= bus.CFG_PERIOD;
              if (cfg_legal) begin
                busy_q <= 1'b1;
                if (go_high) begin
                  state <= HIGH;
                  trg_q <= 1'b1;
                end else begin
                  state <= DELAY;
                end
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (ph_zero) begin
              state <= HIGH;
              trg_q <= 1'b1;
            end
          end
          HIGH: begin
            if (ph_zero) begin
              trg_q <= 1'b0;
              if (num_zero) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state <= LOW;
              end
            end
          end
          LOW: begin
            if (per_zero) begin
              state <= HIGH;
              trg_q <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            trg_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.TRG_PLS = trg_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.CFG_ERR = err_q;

endmodule

// File: tb/tb_ptmch_trg_seq.sv
// Bench for ptmch_trg_seq: directed scenarios plus random traffic against a
// closed-form model of the pulse train.
module tb_ptmch_trg_seq;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: an active train is fully described by its capture cycle and config.
  bit act = 1'b0;
  int t0  = 0;
  int md  = 0;
  int mw  = 0;
  int mp  = 0;
  int mc  = 0;

  ptmch_trg_seq_if bus ();

  ptmch_trg_seq dut (
    .CLK160M (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0b, expected %0b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance one edge, then compare against the model.
  task automatic applyStimulus(input bit st, input bit ab, input bit rs,
                               input int d, input int w, input int p, input int c);
    logic e_trg;
    logic e_busy;
    logic e_done;
    logic e_err;
    int   j;
    int   fin;
    bus.START      = st;
    bus.ABORT      = ab;
    bus.CFG_DELAY  = 16'(d);
    bus.CFG_WIDTH  = 16'(w);
    bus.CFG_PERIOD = 16'(p);
    bus.CFG_COUNT  = 8'(c);
    rst            = rs;
    @(posedge clk);
    cyc++;
    e_trg  = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (rs) begin
      act = 1'b0;
    end else if (act && ab) begin
      act = 1'b0;
    end else begin
      if (!act && st && !ab) begin
        if (w >= 1 && c >= 1 && p > w) begin
          act = 1'b1;
          t0  = cyc;
          md  = d;
          mw  = w;
          mp  = p;
          mc  = c;
        end else begin
          e_err = 1'b1;
        end
      end
      if (act) begin
        j      = cyc - t0;
        fin    = md + (mc - 1) * mp + mw;
        e_busy = (j < fin);
        e_done = (j == fin);
        e_trg  = (j >= md) && (j < fin) && (((j - md) % mp) < mw);
        if (j == fin) act = 1'b0;
      end
    end
    #1;
    checkOutput($sformatf("trg@%0d", cyc),  bus.TRG_PLS, e_trg);
    checkOutput($sformatf("busy@%0d", cyc), bus.BUSY,    e_busy);
    checkOutput($sformatf("done@%0d", cyc), bus.DONE,    e_done);
    checkOutput($sformatf("err@%0d", cyc),  bus.CFG_ERR, e_err);
  endtask

  // Idle cycles keep scrambling CFG so that post-capture changes are exercised.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9));
  endtask

  task automatic startTrain(input int d, input int w, input int p, input int c);
    applyStimulus(1'b1, 1'b0, 1'b0, d, w, p, c);
  endtask

  initial begin
    $display("[TB] ptmch_trg_seq bench starting");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    idleCycles(2);

    // Reference train and the minimal single pulse.
    startTrain(2, 3, 5, 3);
    idleCycles(20);
    startTrain(0, 1, 2, 1);
    idleCycles(4);

    // Illegal configurations.
    startTrain(5, 0, 6, 2);
    idleCycles(2);
    startTrain(1, 2, 5, 0);
    idleCycles(2);
    startTrain(1, 4, 4, 1);
    idleCycles(2);

    // Abort, then reset, in the middle of the reference train.
    startTrain(2, 3, 5, 3);
    idleCycles(8);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    idleCycles(10);
    startTrain(2, 3, 5, 3);
    idleCycles(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    idleCycles(10);

    // Second START while busy must be ignored.
    startTrain(2, 3, 5, 3);
    idleCycles(3);
    startTrain(0, 1, 2, 7);
    idleCycles(15);

    // New START in the DONE cycle.
    startTrain(2, 3, 5, 3);
    idleCycles(15);
    startTrain(1, 2, 4, 2);
    idleCycles(10);

    // START with ABORT while idle, and ABORT alone while idle.
    applyStimulus(1'b1, 1'b1, 1'b0, 1, 1, 2, 1);
    idleCycles(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 1, 2, 1);
    idleCycles(2);

    // Full-scale period is legal.
    startTrain(0, 1, 65535, 2);
    idleCycles(6);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    idleCycles(2);

    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 199) == 0, $urandom_range(0, 6),
                    $urandom_range(0, 4), $urandom_range(0, 8), $urandom_range(0, 4));
    idleCycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
